ap_fifo_rr_sched: RTL and testbench

- Time-shares one HLS ap_fifo core (single in stream, single out stream, one output word per input word) between two host stream channels.
- Each channel is an ap_fifo-style source/sink pair fed by the Xillybus-side async FIFOs.
- Grants the core to one channel per burst, round-robin, and routes the core's results back to the channel that supplied the inputs.
- A burst closes only once every issued word has returned, so results never cross channels.

---
 rtl/ap_fifo_rr_sched_if.sv | 49 ++++
 rtl/ap_fifo_rr_sched.sv | 130 +++++++++++++
 tb/tb_ap_fifo_rr_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ap_fifo_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : ap_fifo_rr_sched_if
// Brief    : ap_fifo stream bundle: two host channels plus the shared core.
// Revision : 1.0
// ============================================================================
interface ap_fifo_rr_sched_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] ch0_in_dout;
    logic              ch0_in_empty_n;
    logic              ch0_in_read;
    logic [DATA_W-1:0] ch0_out_din;
    logic              ch0_out_full_n;
    logic              ch0_out_write;

    logic [DATA_W-1:0] ch1_in_dout;
    logic              ch1_in_empty_n;
    logic              ch1_in_read;
    logic [DATA_W-1:0] ch1_out_din;
    logic              ch1_out_full_n;
    logic              ch1_out_write;

    logic [DATA_W-1:0] ip_in_dout;
    logic              ip_in_empty_n;
    logic              ip_in_read;
    logic [DATA_W-1:0] ip_out_din;
    logic              ip_out_full_n;
    logic              ip_out_write;

    modport master (
        input  ch0_in_dout, ch0_in_empty_n, ch0_out_full_n,
        output ch0_in_read, ch0_out_din, ch0_out_write,
        input  ch1_in_dout, ch1_in_empty_n, ch1_out_full_n,
        output ch1_in_read, ch1_out_din, ch1_out_write,
        output ip_in_dout, ip_in_empty_n, ip_out_full_n,
        input  ip_in_read, ip_out_din, ip_out_write
    );

    modport slave (
        output ch0_in_dout, ch0_in_empty_n, ch0_out_full_n,
        input  ch0_in_read, ch0_out_din, ch0_out_write,
        output ch1_in_dout, ch1_in_empty_n, ch1_out_full_n,
        input  ch1_in_read, ch1_out_din, ch1_out_write,
        input  ip_in_dout, ip_in_empty_n, ip_out_full_n,
        output ip_in_read, ip_out_din, ip_out_write
    );
endinterface
`default_nettype wire

// File: rtl/ap_fifo_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : ap_fifo_rr_sched
// Brief    : Round-robin burst time-sharing of one ap_fifo core by two channels.
// Revision : 1.0
// ============================================================================
module ap_fifo_rr_sched #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 64,
    parameter int CNT_W     = 16,
    parameter int IDLE_TO   = 32
) (
    input  wire logic          ap_clk,
    input  wire logic          ap_rst,
    input  wire logic [1:0]    ch_en,
    ap_fifo_rr_sched_if.master fifo,
    output logic      [1:0]    grant,
    output logic               busy
);

    localparam int               c_to_w    = $clog2(IDLE_TO + 1);
    localparam logic [CNT_W-1:0] c_burst   = CNT_W'(BURST_LEN);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(IDLE_TO - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_grant;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [c_to_w-1:0] r_to_cnt;
    logic              r_last;

    logic              w_sel;
    logic              w_run;
    logic              w_active;
    logic              w_en;
    logic              w_src_empty_n;
    logic              w_sink_full_n;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [CNT_W-1:0]  w_in_next;
    logic [1:0]        w_req;
    logic              w_pick;

    assign w_sel         = r_grant[1];
    assign w_run         = (r_state == c_st_run);
    assign w_active      = w_run || (r_state == c_st_drain);
    assign w_en          = ch_en[w_sel];
    assign w_src_empty_n = w_sel ? fifo.ch1_in_empty_n : fifo.ch0_in_empty_n;
    assign w_sink_full_n = w_sel ? fifo.ch1_out_full_n : fifo.ch0_out_full_n;

    // A dropped enable blocks issue in the same cycle, not one cycle later.
    assign fifo.ip_in_empty_n = w_run && w_en && w_src_empty_n && (r_in_cnt < c_burst);
    assign fifo.ip_out_full_n = w_active && w_sink_full_n && (r_out_cnt < r_in_cnt);
    assign fifo.ip_in_dout    = r_grant[0] ? fifo.ch0_in_dout :
                                (r_grant[1] ? fifo.ch1_in_dout : {DATA_W{1'b0}});

    assign w_in_fire  = fifo.ip_in_read && fifo.ip_in_empty_n;
    assign w_out_fire = fifo.ip_out_write && fifo.ip_out_full_n;
    assign w_in_next  = r_in_cnt + CNT_W'(w_in_fire);

    assign fifo.ch0_in_read   = r_grant[0] && w_in_fire;
    assign fifo.ch1_in_read   = r_grant[1] && w_in_fire;
    assign fifo.ch0_out_write = r_grant[0] && w_out_fire;
    assign fifo.ch1_out_write = r_grant[1] && w_out_fire;
    assign fifo.ch0_out_din   = fifo.ip_out_din;
    assign fifo.ch1_out_din   = fifo.ip_out_din;

    assign w_req  = ch_en & {fifo.ch1_in_empty_n, fifo.ch0_in_empty_n};
    // Channel index of the winner; only meaningful when some channel requests.
    assign w_pick = w_req[0] ? (w_req[1] ? ~r_last : 1'b0) : 1'b1;

    assign grant = r_grant;
    assign busy  = (r_state != c_st_idle);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state   <= c_st_idle;
            r_grant   <= 2'b00;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_to_cnt  <= '0;
            r_last    <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|w_req) begin
                        r_grant   <= w_pick ? 2'b10 : 2'b01;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_to_cnt  <= '0;
                        r_state   <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_in_cnt  <= w_in_next;
                    r_out_cnt <= r_out_cnt + CNT_W'(w_out_fire);
                    if (w_in_fire) begin
                        r_to_cnt <= '0;
                    end else if (r_to_cnt != c_to_last) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                    if ((w_in_next == c_burst) || !w_en ||
                        (!w_in_fire && (r_to_cnt == c_to_last))) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    // Results still owed keep the grant; equality closes the burst.
                    if (r_out_cnt == r_in_cnt) begin
                        r_last  <= w_sel;
                        r_grant <= 2'b00;
                        r_state <= c_st_idle;
                    end else begin
                        r_out_cnt <= r_out_cnt + CNT_W'(w_out_fire);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ap_fifo_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ap_fifo_rr_sched
// Brief    : Directed bench: FIFO/core models around ap_fifo_rr_sched.
// Revision : 1.0
// ============================================================================
module tb_ap_fifo_rr_sched;

    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 64;
    localparam int IDLE_TO   = 32;

    logic       ap_clk = 1'b0;
    logic       ap_rst = 1'b1;
    logic [1:0] ch_en  = 2'b00;
    logic [1:0] grant;
    logic       busy;

    ap_fifo_rr_sched_if #(.DATA_W(DATA_W)) bus ();

    ap_fifo_rr_sched #(
        .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(16), .IDLE_TO(IDLE_TO)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .ch_en (ch_en),
        .fifo  (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] src0[$], src1[$], rcv0[$], rcv1[$], core_q[$];
    logic [1:0]  grant_log[$];
    int          blen_log[$];
    logic [1:0]  sink_rdy    = 2'b11;
    logic [1:0]  prev_grant  = 2'b00;
    int          n_in0 = 0, n_in1 = 0, cyc = 0, last_in_cyc = 0, viol = 0;

    bit          f_in0, f_in1, f_ipin, f_ipout, f_out0, f_out1, rst_s;
    logic [31:0] d_ipin, d_out0, d_out1;
    logic [1:0]  g_s;

    function automatic void drive_env();
        bus.ch0_in_empty_n = (src0.size() > 0);
        bus.ch0_in_dout    = (src0.size() > 0) ? src0[0] : 32'h0;
        bus.ch1_in_empty_n = (src1.size() > 0);
        bus.ch1_in_dout    = (src1.size() > 0) ? src1[0] : 32'h0;
        bus.ch0_out_full_n = sink_rdy[0];
        bus.ch1_out_full_n = sink_rdy[1];
        bus.ip_in_read     = (core_q.size() < 4);
        bus.ip_out_write   = (core_q.size() > 0);
        bus.ip_out_din     = (core_q.size() > 0) ? core_q[0] : 32'h0;
    endfunction

    // Source/sink FIFOs and a 4-deep loopback core; transfers resolved at the edge.
    initial begin
        drive_env();
        forever begin
            @(posedge ap_clk);
            f_in0   = bus.ch0_in_read && bus.ch0_in_empty_n;
            f_in1   = bus.ch1_in_read && bus.ch1_in_empty_n;
            f_ipin  = bus.ip_in_read && bus.ip_in_empty_n;
            f_ipout = bus.ip_out_write && bus.ip_out_full_n;
            f_out0  = bus.ch0_out_write && bus.ch0_out_full_n;
            f_out1  = bus.ch1_out_write && bus.ch1_out_full_n;
            d_ipin  = bus.ip_in_dout;
            d_out0  = bus.ch0_out_din;
            d_out1  = bus.ch1_out_din;
            g_s     = grant;
            rst_s   = ap_rst;
            cyc++;
            if (g_s != 2'b00 && prev_grant == 2'b00) begin
                grant_log.push_back(g_s);
                blen_log.push_back(0);
            end
            prev_grant = g_s;
            if ((bus.ch0_in_read || bus.ch0_out_write) && g_s != 2'b01) viol++;
            if ((bus.ch1_in_read || bus.ch1_out_write) && g_s != 2'b10) viol++;
            if (f_ipin != (f_in0 || f_in1)) viol++;
            if (f_in0 && src0.size() > 0 && d_ipin !== src0[0]) viol++;
            if (f_in1 && src1.size() > 0 && d_ipin !== src1[0]) viol++;
            #1;
            if (f_in0) begin void'(src0.pop_front()); n_in0++; end
            if (f_in1) begin void'(src1.pop_front()); n_in1++; end
            if (f_in0 || f_in1) begin
                last_in_cyc = cyc;
                if (blen_log.size() > 0) blen_log[blen_log.size()-1]++;
            end
            if (f_out0) rcv0.push_back(d_out0);
            if (f_out1) rcv1.push_back(d_out1);
            if (f_ipout) void'(core_q.pop_front());
            if (f_ipin) core_q.push_back(d_ipin);
            if (rst_s) core_q.delete();
            drive_env();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_grant(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge ap_clk);
            if (grant != 2'b00) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge ap_clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        ch_en  = 2'b11;
        repeat (3) @(negedge ap_clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++;
        if ({bus.ch0_in_read, bus.ch1_in_read, bus.ch0_out_write, bus.ch1_out_write} !== 4'b0000) begin
            errors++; $display("FAIL rst_rd_wr: got %b want 0000",
                {bus.ch0_in_read, bus.ch1_in_read, bus.ch0_out_write, bus.ch1_out_write});
        end
        checks++;
        if ({bus.ip_in_empty_n, bus.ip_out_full_n} !== 2'b00) begin
            errors++; $display("FAIL rst_ip_flags: got %b want 00", {bus.ip_in_empty_n, bus.ip_out_full_n});
        end
        checks++; if (bus.ip_in_dout !== 32'h0) begin errors++; $display("FAIL rst_ip_dout: got %h want 0", bus.ip_in_dout); end
        ap_rst = 1'b0;
        repeat (2) @(negedge ap_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy %b want 0", busy); end
    endtask

    task automatic test_single();
        bit ok;
        rcv0.delete(); rcv1.delete();
        ch_en = 2'b01;
        for (int i = 0; i < 10; i++) src0.push_back(32'hA000_0000 + i);
        wait_grant(20, ok);
        checks++; if (!ok || grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_idle: busy still %b after 300 cycles, want 0", busy); end
        checks++;
        if (cyc - last_in_cyc != IDLE_TO + 1) begin
            errors++; $display("FAIL single_close: idle after %0d cycles want %0d", cyc - last_in_cyc, IDLE_TO + 1);
        end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_grant_end: got %b want 00", grant); end
        checks++; if (rcv0.size() != 10 || rcv1.size() != 0) begin
            errors++; $display("FAIL single_counts: ch0 %0d ch1 %0d want 10 0", rcv0.size(), rcv1.size());
        end
        for (int i = 0; i < 10 && i < rcv0.size(); i++) begin
            checks++; if (rcv0[i] !== 32'hA000_0000 + i) begin
                errors++; $display("FAIL single_word%0d: got %h want %h", i, rcv0[i], 32'hA000_0000 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [1:0] exp_g;
        int exp_len;
        int v0;
        rcv0.delete(); rcv1.delete(); grant_log.delete(); blen_log.delete();
        v0 = viol;
        ch_en = 2'b11;
        for (int i = 0; i < 200; i++) begin
            src0.push_back(32'hA100_0000 + i);
            src1.push_back(32'hB100_0000 + i);
        end
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge ap_clk);
            if (src0.size() == 0 && src1.size() == 0 && !busy) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL b2b_done: src0 %0d src1 %0d left, want 0 0", src0.size(), src1.size()); end
        checks++; if (grant_log.size() != 8) begin errors++; $display("FAIL b2b_nbursts: got %0d want 8", grant_log.size()); end
        // Last grant went to ch0, so ch1 opens; both end on an 8-word tail burst.
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            exp_g   = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_len = (i < 6) ? 64 : 8;
            checks++; if (grant_log[i] !== exp_g) begin
                errors++; $display("FAIL b2b_grant%0d: got %b want %b", i, grant_log[i], exp_g);
            end
            checks++; if (blen_log[i] != exp_len) begin
                errors++; $display("FAIL b2b_len%0d: got %0d want %0d", i, blen_log[i], exp_len);
            end
        end
        checks++; if (rcv0.size() != 200 || rcv1.size() != 200) begin
            errors++; $display("FAIL b2b_counts: ch0 %0d ch1 %0d want 200 200", rcv0.size(), rcv1.size());
        end
        for (int i = 0; i < 200; i++) begin
            if (i < rcv0.size()) begin
                checks++; if (rcv0[i] !== 32'hA100_0000 + i) begin
                    errors++; $display("FAIL b2b_ch0_word%0d: got %h want %h", i, rcv0[i], 32'hA100_0000 + i);
                end
            end
            if (i < rcv1.size()) begin
                checks++; if (rcv1[i] !== 32'hB100_0000 + i) begin
                    errors++; $display("FAIL b2b_ch1_word%0d: got %h want %h", i, rcv1[i], 32'hB100_0000 + i);
                end
            end
        end
        checks++; if (viol != v0) begin errors++; $display("FAIL b2b_protocol: %0d violations want 0", viol - v0); end
    endtask

    task automatic test_timeout();
        bit ok;
        rcv0.delete(); rcv1.delete();
        ch_en = 2'b11;
        for (int i = 0; i < 5; i++) src1.push_back(32'hB200_0000 + i);
        wait_grant(20, ok);
        checks++; if (!ok || grant !== 2'b10) begin errors++; $display("FAIL to_grant: got %b want 10", grant); end
        for (int i = 0; i < 3; i++) src0.push_back(32'hA200_0000 + i);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_idle: busy still %b, want 0", busy); end
        checks++;
        if (cyc - last_in_cyc != IDLE_TO + 1) begin
            errors++; $display("FAIL to_close: idle after %0d cycles want %0d", cyc - last_in_cyc, IDLE_TO + 1);
        end
        checks++; if (rcv1.size() != 5 || rcv0.size() != 0) begin
            errors++; $display("FAIL to_counts: ch1 %0d ch0 %0d want 5 0", rcv1.size(), rcv0.size());
        end
        for (int i = 0; i < 5 && i < rcv1.size(); i++) begin
            checks++; if (rcv1[i] !== 32'hB200_0000 + i) begin
                errors++; $display("FAIL to_word%0d: got %h want %h", i, rcv1[i], 32'hB200_0000 + i);
            end
        end
        wait_grant(10, ok);
        checks++; if (!ok || grant !== 2'b01) begin errors++; $display("FAIL to_next_grant: got %b want 01", grant); end
        wait_idle(200, ok);
        checks++; if (!ok || rcv0.size() != 3) begin errors++; $display("FAIL to_ch0_words: got %0d want 3", rcv0.size()); end
    endtask

    task automatic test_sink_stall();
        bit ok;
        int n;
        rcv0.delete(); rcv1.delete();
        ch_en = 2'b01;
        for (int i = 0; i < 64; i++) src0.push_back(32'hA300_0000 + i);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            if (rcv0.size() >= 10) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL stall_start: got %0d words want >=10", rcv0.size()); end
        sink_rdy = 2'b10;
        repeat (10) @(negedge ap_clk);
        checks++; if (bus.ip_out_full_n !== 1'b0) begin errors++; $display("FAIL stall_full_n: got %b want 0", bus.ip_out_full_n); end
        checks++; if (bus.ch0_in_read !== 1'b0) begin errors++; $display("FAIL stall_core: in_read %b want 0", bus.ch0_in_read); end
        n = rcv0.size();
        repeat (40) @(negedge ap_clk);
        checks++; if (rcv0.size() != n) begin errors++; $display("FAIL stall_hold: got %0d words want %0d", rcv0.size(), n); end
        sink_rdy = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge ap_clk);
            if (src0.size() == 0 && !busy) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || rcv0.size() != 64) begin errors++; $display("FAIL stall_total: got %0d want 64", rcv0.size()); end
        for (int i = 0; i < 64 && i < rcv0.size(); i++) begin
            checks++; if (rcv0[i] !== 32'hA300_0000 + i) begin
                errors++; $display("FAIL stall_word%0d: got %h want %h", i, rcv0[i], 32'hA300_0000 + i);
            end
        end
    endtask

    task automatic test_en_drop();
        bit ok;
        int base;
        int v0;
        rcv0.delete(); rcv1.delete();
        v0 = viol;
        ch_en = 2'b01;
        base = n_in0;
        for (int i = 0; i < 64; i++) src0.push_back(32'hA400_0000 + i);
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            if (n_in0 - base >= 20) break;
        end
        ch_en = 2'b00;
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_idle: busy still %b want 0", busy); end
        repeat (5) @(negedge ap_clk);
        checks++; if (n_in0 - base != 20) begin errors++; $display("FAIL drop_reads: got %0d want 20", n_in0 - base); end
        checks++; if (blen_log.size() == 0 || blen_log[blen_log.size()-1] != 20) begin
            errors++; $display("FAIL drop_burst_len: got %0d want 20",
                (blen_log.size() == 0) ? -1 : blen_log[blen_log.size()-1]);
        end
        checks++; if (rcv0.size() != 20) begin errors++; $display("FAIL drop_drained: got %0d want 20", rcv0.size()); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL drop_grant: got %b want 00", grant); end
        checks++; if (viol != v0) begin errors++; $display("FAIL drop_protocol: %0d violations want 0", viol - v0); end
        src0.delete();
        @(negedge ap_clk);
    endtask

    task automatic test_mid_reset();
        bit ok;
        int base;
        ch_en = 2'b11;
        for (int i = 0; i < 64; i++) begin
            src0.push_back(32'hA500_0000 + i);
            src1.push_back(32'hB500_0000 + i);
        end
        wait_grant(20, ok);
        checks++; if (!ok || grant !== 2'b10) begin errors++; $display("FAIL mr_grant: got %b want 10", grant); end
        base = n_in1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            if (n_in1 - base >= 30) break;
        end
        ap_rst = 1'b1;
        @(negedge ap_clk);
        checks++; if (grant !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL mr_state: grant %b busy %b want 00 0", grant, busy);
        end
        checks++;
        if ({bus.ch0_in_read, bus.ch1_in_read, bus.ch0_out_write, bus.ch1_out_write,
             bus.ip_in_empty_n, bus.ip_out_full_n} !== 6'b000000) begin
            errors++; $display("FAIL mr_handshake: got %b want 000000",
                {bus.ch0_in_read, bus.ch1_in_read, bus.ch0_out_write, bus.ch1_out_write,
                 bus.ip_in_empty_n, bus.ip_out_full_n});
        end
        checks++; if (bus.ip_in_dout !== 32'h0) begin errors++; $display("FAIL mr_dout: got %h want 0", bus.ip_in_dout); end
        ap_rst = 1'b0;
        wait_grant(10, ok);
        checks++; if (!ok || grant !== 2'b01) begin errors++; $display("FAIL mr_first_grant: got %b want 01", grant); end
        ch_en = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_sink_stall();
        test_en_drop();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
